nios_system_cursor_pio: RTL and testbench

NIOS_SYSTEM_CURSOR_PIO -- requirements
Module: nios_system_cursor_pio

---
 rtl/nios_system_cursor_pio.sv | 163 ++++++++++++++++
 tb/tb_nios_system_cursor_pio.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/nios_system_cursor_pio.sv
// Avalon-MM cursor coordinate register with bounded step up/down, saturate or wrap,
// sticky overflow flag and a coalescing update handshake towards the display side.
module nios_system_cursor_pio #(
    parameter int WIDTH     = 10,
    parameter int MAX_VAL   = 639,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic             hw_inc,
    input  logic             hw_dec,
    output logic [WIDTH-1:0] out_port,
    output logic             upd_valid,
    input  logic             upd_ready
);

    localparam logic [WIDTH-1:0] L_MAX   = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] L_RST   = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] L_ONE   = WIDTH'(1);
    localparam logic [WIDTH:0]   L_MAX_X = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH:0]   L_MOD   = (WIDTH+1)'(MAX_VAL + 1);

    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] r_step;
    logic             r_wrap;
    logic             r_ovf;
    logic             r_upd_valid;

    logic             w_wr;
    logic             w_data_wr;
    logic             w_step_wr;
    logic             w_ctrl_wr;
    logic             w_cmd_wr;
    logic             w_stat_wr;
    logic             w_cmd_req;
    logic [WIDTH-1:0] w_wd;
    logic             w_wd_ovf;
    logic [WIDTH-1:0] w_wd_clamped;
    logic             w_inc;
    logic             w_dec;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_sum_wrap;
    logic             w_inc_ovf;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH:0]   w_dec_wrap;
    logic             w_dec_ovf;
    logic [WIDTH-1:0] w_next_data;
    logic             w_set_ovf;
    logic             w_changed;
    logic             w_at_max;
    logic             w_at_min;
    logic             w_unused_wd;

    assign w_wr      = chipselect & ~write_n;
    assign w_data_wr = w_wr & (address == 3'd0);
    assign w_step_wr = w_wr & (address == 3'd1);
    assign w_ctrl_wr = w_wr & (address == 3'd2);
    assign w_cmd_wr  = w_wr & (address == 3'd3);
    assign w_stat_wr = w_wr & (address == 3'd4);
    // A CMD write only counts as a request (and masks the hw pins) when a step bit is set.
    assign w_cmd_req = w_cmd_wr & (writedata[0] | writedata[1]);

    assign w_wd         = writedata[WIDTH-1:0];
    assign w_wd_ovf     = (w_wd > L_MAX);
    assign w_wd_clamped = w_wd_ovf ? L_MAX : w_wd;
    assign w_unused_wd  = &{1'b0, writedata};

    assign w_sum      = {1'b0, r_data} + {1'b0, r_step};
    assign w_sum_wrap = w_sum - L_MOD;
    assign w_inc_ovf  = (w_sum > L_MAX_X);
    assign w_diff     = r_data - r_step;
    assign w_dec_wrap = {1'b0, r_data} + L_MOD - {1'b0, r_step};
    assign w_dec_ovf  = (r_data < r_step);

    always_comb begin
        w_inc = 1'b0;
        w_dec = 1'b0;
        if (w_data_wr) begin
            w_inc = 1'b0;
            w_dec = 1'b0;
        end else if (w_cmd_req) begin
            w_inc = writedata[0] & ~writedata[1];
            w_dec = writedata[1] & ~writedata[0];
        end else begin
            w_inc = hw_inc & ~hw_dec;
            w_dec = hw_dec & ~hw_inc;
        end
    end

    always_comb begin
        w_next_data = r_data;
        w_set_ovf   = 1'b0;
        if (w_data_wr) begin
            w_next_data = w_wd_clamped;
            w_set_ovf   = w_wd_ovf;
        end else if (w_inc) begin
            w_set_ovf = w_inc_ovf;
            if (!w_inc_ovf)
                w_next_data = w_sum[WIDTH-1:0];
            else if (r_wrap)
                w_next_data = w_sum_wrap[WIDTH-1:0];
            else
                w_next_data = L_MAX;
        end else if (w_dec) begin
            w_set_ovf = w_dec_ovf;
            if (!w_dec_ovf)
                w_next_data = w_diff;
            else if (r_wrap)
                w_next_data = w_dec_wrap[WIDTH-1:0];
            else
                w_next_data = '0;
        end
    end

    assign w_changed = (w_next_data != r_data);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data      <= L_RST;
            r_step      <= L_ONE;
            r_wrap      <= 1'b0;
            r_ovf       <= 1'b0;
            r_upd_valid <= 1'b0;
        end else begin
            r_data <= w_next_data;
            if (w_step_wr)
                r_step <= w_wd_clamped;
            if (w_ctrl_wr)
                r_wrap <= writedata[0];
            if (w_set_ovf)
                r_ovf <= 1'b1;
            else if (w_stat_wr && writedata[3])
                r_ovf <= 1'b0;
            // A fresh change keeps the flag up even if the old value is consumed now.
            if (w_changed)
                r_upd_valid <= 1'b1;
            else if (r_upd_valid && upd_ready)
                r_upd_valid <= 1'b0;
        end
    end

    assign w_at_max  = (r_data == L_MAX);
    assign w_at_min  = (r_data == '0);
    assign out_port  = r_data;
    assign upd_valid = r_upd_valid;

    always_comb begin
        readdata = 32'd0;
        case (address)
            3'd0:    readdata = 32'(r_data);
            3'd1:    readdata = 32'(r_step);
            3'd2:    readdata = {31'd0, r_wrap};
            3'd4:    readdata = {28'd0, r_ovf, w_at_min, w_at_max, r_upd_valid};
            default: readdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_nios_system_cursor_pio.sv
// Directed bench for nios_system_cursor_pio: stimulus queues expectations per cycle,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_nios_system_cursor_pio;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        hw_inc;
    logic        hw_dec;
    logic [9:0]  out_port;
    logic        upd_valid;
    logic        upd_ready;

    always #5 clk = ~clk;

    nios_system_cursor_pio #(.WIDTH(10), .MAX_VAL(639), .RESET_VAL(0)) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .hw_inc     (hw_inc),
        .hw_dec     (hw_dec),
        .out_port   (out_port),
        .upd_valid  (upd_valid),
        .upd_ready  (upd_ready)
    );

    int          cycnt   = 0;
    int          n_tests = 0;
    int          n_fail  = 0;
    logic        ready_q = 1'b1;

    int          q_cyc[$];
    int          q_sel[$];
    logic [31:0] q_exp[$];
    string       q_name[$];

    always @(posedge clk) cycnt <= cycnt + 1;

    // sel: 0 = out_port, 1 = upd_valid, 2 = readdata
    always @(negedge clk) begin
        int          c;
        int          s;
        logic [31:0] e;
        string       nm;
        logic [31:0] act;
        while (q_cyc.size() > 0 && q_cyc[0] <= cycnt) begin
            c  = q_cyc.pop_front();
            s  = q_sel.pop_front();
            e  = q_exp.pop_front();
            nm = q_name.pop_front();
            case (s)
                0:       act = 32'(out_port);
                1:       act = {31'd0, upd_valid};
                default: act = readdata;
            endcase
            n_tests++;
            if (c != cycnt || act !== e) begin
                n_fail++;
                $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d, due %0d)", nm, act, e, cycnt, c);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic cs, input logic wn, input logic [2:0] a,
                         input logic [31:0] d, input logic inc, input logic dec);
        tick();
        reset      = 1'b0;
        chipselect = cs;
        write_n    = wn;
        address    = a;
        writedata  = d;
        hw_inc     = inc;
        hw_dec     = dec;
        upd_ready  = ready_q;
    endtask

    task automatic idle();
        drive(1'b0, 1'b1, 3'd0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        drive(1'b1, 1'b0, a, d, 1'b0, 1'b0);
    endtask

    task automatic expect_v(input int sel, input logic [31:0] val, input string nm);
        q_cyc.push_back(cycnt);
        q_sel.push_back(sel);
        q_exp.push_back(val);
        q_name.push_back(nm);
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] val, input string nm);
        drive(1'b0, 1'b1, a, 32'd0, 1'b0, 1'b0);
        expect_v(2, val, nm);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 3'd0;
        writedata  = 32'd0;
        hw_inc     = 1'b0;
        hw_dec     = 1'b0;
        upd_ready  = 1'b1;
        repeat (3) @(posedge clk);
        idle();

        // Reset state and register map
        rd(3'd0, 32'd0, "rst_data");
        expect_v(0, 32'd0, "rst_out_port");
        expect_v(1, 32'd0, "rst_upd_valid");
        rd(3'd1, 32'd1, "rst_step");
        rd(3'd2, 32'd0, "rst_ctrl");
        rd(3'd3, 32'd0, "cmd_reads_0");
        rd(3'd4, 32'h4, "rst_status");
        rd(3'd6, 32'd0, "unmapped_reads_0");

        // DATA overflow clamps and sets OVF, W1C clears it
        wr(3'd0, 32'd700);
        idle();
        expect_v(0, 32'd639, "data_clamp");
        expect_v(1, 32'd1, "data_clamp_valid");
        rd(3'd4, 32'hA, "status_ovf_atmax");
        wr(3'd4, 32'h8);
        rd(3'd4, 32'h2, "status_ovf_cleared");

        // Increment: saturate then wrap
        wr(3'd0, 32'd635);
        wr(3'd1, 32'd10);
        wr(3'd2, 32'd0);
        drive(1'b0, 1'b1, 3'd0, 32'd0, 1'b1, 1'b0);
        idle();
        expect_v(0, 32'd639, "inc_saturate");
        expect_v(1, 32'd1, "inc_saturate_valid");
        rd(3'd4, 32'hA, "inc_saturate_ovf");
        wr(3'd2, 32'd1);
        rd(3'd2, 32'd1, "ctrl_wrap_set");
        wr(3'd0, 32'd635);
        drive(1'b0, 1'b1, 3'd0, 32'd0, 1'b1, 1'b0);
        idle();
        expect_v(0, 32'd5, "inc_wrap");

        // Decrement wrap via CMD, then CMD=0x3 no-op
        wr(3'd4, 32'h8);
        wr(3'd0, 32'd3);
        wr(3'd3, 32'h2);
        idle();
        expect_v(0, 32'd633, "dec_wrap");
        wr(3'd3, 32'h3);
        idle();
        expect_v(0, 32'd633, "cmd_both_noop");
        expect_v(1, 32'd0, "cmd_both_no_valid");
        rd(3'd4, 32'h8, "dec_wrap_ovf");

        // Coalescing with upd_ready held low
        wr(3'd2, 32'd0);
        wr(3'd1, 32'd1);
        wr(3'd0, 32'd0);
        idle();
        idle();
        expect_v(1, 32'd0, "valid_consumed");
        ready_q = 1'b0;
        drive(1'b0, 1'b1, 3'd0, 32'd0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 3'd0, 32'd0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 3'd0, 32'd0, 1'b1, 1'b0);
        idle();
        expect_v(0, 32'd3, "coalesce_out");
        expect_v(1, 32'd1, "coalesce_valid");
        idle();
        expect_v(1, 32'd1, "coalesce_valid_held");
        ready_q = 1'b1;
        idle();
        expect_v(1, 32'd1, "valid_before_accept");
        idle();
        expect_v(1, 32'd0, "valid_after_accept");

        // Priority: DATA write > CMD > hw
        drive(1'b1, 1'b0, 3'd0, 32'd100, 1'b1, 1'b0);
        idle();
        expect_v(0, 32'd100, "prio_data_over_hw");
        drive(1'b1, 1'b0, 3'd3, 32'h1, 1'b0, 1'b1);
        idle();
        expect_v(0, 32'd101, "prio_cmd_over_hw");

        // STEP=0 leaves DATA unchanged; STEP write clamps
        wr(3'd1, 32'd0);
        drive(1'b0, 1'b1, 3'd0, 32'd0, 1'b1, 1'b0);
        idle();
        expect_v(0, 32'd101, "step0_no_change");
        expect_v(1, 32'd0, "step0_no_valid");
        wr(3'd1, 32'd1000);
        rd(3'd1, 32'd639, "step_clamp");

        // Reset during CMD write with a pending update
        ready_q = 1'b0;
        wr(3'd0, 32'd200);
        drive(1'b1, 1'b0, 3'd3, 32'h1, 1'b0, 1'b0);
        reset = 1'b1;
        expect_v(0, 32'd200, "pre_reset_out");
        expect_v(1, 32'd1, "pre_reset_valid");
        ready_q = 1'b1;
        idle();
        expect_v(0, 32'd0, "reset_out");
        expect_v(1, 32'd0, "reset_valid");
        rd(3'd1, 32'd1, "reset_step");

        idle();
        idle();
        if (q_cyc.size() != 0) begin
            n_tests += q_cyc.size();
            n_fail  += q_cyc.size();
            $display("FAIL unchecked_expectations: got %0d left expected 0", q_cyc.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
